// File: rtl/cricket_ball_tracker.sv
// Per-team legal-ball / extras tracker with over and inning-limit detection and LED ball display.
// Optional macro CRICKET_SCROLL_EN: scrolling LED pattern while game_over is high.
module cricket_ball_tracker #(
  parameter int unsigned NUM_TEAMS      = 2,
  parameter int unsigned BALL_W         = 7,
  parameter int unsigned EXTRA_W        = 5,
  parameter int unsigned LED_W          = 8,
  parameter int unsigned BALLS_PER_OVER = 6,
  parameter int unsigned MAX_OVERS      = 5,
  parameter int unsigned WIDE_CODE      = 13,
  parameter int unsigned NOBALL_CODE    = 14,
  parameter int unsigned SCROLL_DIV     = 25000000,
  localparam int unsigned TW            = (NUM_TEAMS > 1) ? $clog2(NUM_TEAMS) : 1
) (
  input  logic                           clk_fpga,
  input  logic                           reset,
  input  logic [TW-1:0]                  team_sel,
  input  logic                           delivery,
  input  logic [3:0]                     outcome,
  input  logic                           game_over,
  output logic [LED_W-1:0]               leds,
  output logic [NUM_TEAMS*BALL_W-1:0]    balls_flat,
  output logic [NUM_TEAMS*EXTRA_W-1:0]   extras_flat,
  output logic [NUM_TEAMS-1:0]           inning_over,
  output logic                           over_done
);

  localparam int unsigned TOTAL = BALLS_PER_OVER * MAX_OVERS;
  localparam int unsigned BIO_W = $clog2(BALLS_PER_OVER + 1);
  localparam int unsigned XW    = BALL_W + LED_W;

  if (BALL_W < $clog2(TOTAL + 1)) begin : g_bad_ball_w
    $error("BALL_W too narrow for BALLS_PER_OVER*MAX_OVERS");
  end
  if (SCROLL_DIV < 1) begin : g_bad_div
    $error("SCROLL_DIV must be at least 1");
  end

  logic [BALL_W-1:0]  balls_q  [NUM_TEAMS];
  logic [BALL_W-1:0]  balls_d  [NUM_TEAMS];
  logic [BIO_W-1:0]   bio_q    [NUM_TEAMS];
  logic [BIO_W-1:0]   bio_d    [NUM_TEAMS];
  logic [EXTRA_W-1:0] extras_q [NUM_TEAMS];
  logic [EXTRA_W-1:0] extras_d [NUM_TEAMS];
  logic [NUM_TEAMS-1:0] inning_q, inning_d;
  logic               over_done_q, over_done_d;
  logic [LED_W-1:0]   leds_q, leds_d;

  logic               sel_ok_c;
  logic               sel_inning_c;
  logic               accept_c;
  logic               is_extra_c;
  logic [BALL_W-1:0]  sel_balls_c;
  logic [XW-1:0]      sel_ext_c;

`ifdef CRICKET_SCROLL_EN
  localparam int unsigned DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  logic [DIV_W-1:0] div_q, div_d;
  logic             game_over_q;
`endif

  // Next-state: delivery acceptance, counters, flags and LED selection
  always_comb begin
    balls_d      = balls_q;
    bio_d        = bio_q;
    extras_d     = extras_q;
    inning_d     = inning_q;
    over_done_d  = 1'b0;
    leds_d       = leds_q;
    sel_inning_c = 1'b0;
    sel_balls_c  = '0;
`ifdef CRICKET_SCROLL_EN
    div_d        = div_q;
`endif

    sel_ok_c = (32'(team_sel) < NUM_TEAMS);
    for (int t = 0; t < NUM_TEAMS; t++) begin
      if (team_sel == TW'(t)) sel_inning_c = inning_q[t];
    end
    accept_c   = delivery & ~game_over & sel_ok_c & ~sel_inning_c;
    is_extra_c = (outcome == 4'(WIDE_CODE)) || (outcome == 4'(NOBALL_CODE));

    for (int t = 0; t < NUM_TEAMS; t++) begin
      if (accept_c && (team_sel == TW'(t))) begin
        if (is_extra_c) begin
          if (extras_q[t] != {EXTRA_W{1'b1}}) extras_d[t] = extras_q[t] + 1'b1;
        end else begin
          balls_d[t] = balls_q[t] + 1'b1;
          if (bio_q[t] == BIO_W'(BALLS_PER_OVER - 1)) begin
            bio_d[t]    = '0;
            over_done_d = 1'b1;
          end else begin
            bio_d[t] = bio_q[t] + 1'b1;
          end
          if (balls_q[t] == BALL_W'(TOTAL - 1)) begin
            inning_d[t] = 1'b1;
            over_done_d = 1'b1;
          end
        end
      end
    end

    // Display the post-update count so a new ball shows without a stale cycle
    for (int t = 0; t < NUM_TEAMS; t++) begin
      if (team_sel == TW'(t)) sel_balls_c = balls_d[t];
    end
    sel_ext_c = XW'(sel_balls_c);

    if (!game_over) begin
      leds_d = sel_ok_c ? sel_ext_c[LED_W-1:0] : '0;
    end else begin
`ifdef CRICKET_SCROLL_EN
      if (!game_over_q) begin
        leds_d = LED_W'(1);
        div_d  = '0;
      end else if (div_q == DIV_W'(SCROLL_DIV - 1)) begin
        leds_d = (leds_q << 1) | (leds_q >> (LED_W - 1));
        div_d  = '0;
      end else begin
        div_d = div_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      for (int t = 0; t < NUM_TEAMS; t++) begin
        balls_q[t]  <= '0;
        bio_q[t]    <= '0;
        extras_q[t] <= '0;
      end
      inning_q    <= '0;
      over_done_q <= 1'b0;
      leds_q      <= '0;
`ifdef CRICKET_SCROLL_EN
      div_q       <= '0;
      game_over_q <= 1'b0;
`endif
    end else begin
      balls_q     <= balls_d;
      bio_q       <= bio_d;
      extras_q    <= extras_d;
      inning_q    <= inning_d;
      over_done_q <= over_done_d;
      leds_q      <= leds_d;
`ifdef CRICKET_SCROLL_EN
      div_q       <= div_d;
      game_over_q <= game_over;
`endif
    end
  end

  // Flatten per-team registers onto the output buses
  always_comb begin
    balls_flat  = '0;
    extras_flat = '0;
    for (int t = 0; t < NUM_TEAMS; t++) begin
      balls_flat[t*BALL_W +: BALL_W]    = balls_q[t];
      extras_flat[t*EXTRA_W +: EXTRA_W] = extras_q[t];
    end
  end

  assign inning_over = inning_q;
  assign over_done   = over_done_q;
  assign leds        = leds_q;

endmodule
